// File: rtl/hmac_seq_pkg.sv
// Shared types and constants for the HMAC-384 command sequencer.
// Optional zeroize behaviour is selected by HMAC_SEQ_ZEROIZE_EN.
package hmac_seq_pkg;

    localparam int KEY_WORDS   = 12;
    localparam int BLOCK_WORDS = 32;
    localparam int TAG_WORDS   = 12;
    localparam int TOTAL_WORDS = KEY_WORDS + BLOCK_WORDS;

    localparam int KEY_BASE     = 0;
    localparam int BLOCK_BASE   = 12;
    localparam int LAST_ADDR    = 43;
    localparam int ZEROIZE_ADDR = 63;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        CAPTURE
    } seq_state_e;

    // Word 0 is the most-significant tag word; out-of-range selects read as zero.
    function automatic logic [31:0] tag_word(input logic [TAG_WORDS*32-1:0] tag,
                                             input logic [3:0] idx);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < TAG_WORDS; i++) begin
            if (idx == 4'(i)) w = tag[(TAG_WORDS-1-i)*32 +: 32];
        end
        return w;
    endfunction

endpackage

// File: rtl/hmac_seq_wordreg.sv
// 44 x 32 word-addressed register file holding the HMAC key (words 0..11)
// and message block (words 12..43), presented as flattened MSW-first vectors.
module hmac_seq_wordreg
    import hmac_seq_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en_i,
    input  logic [5:0]                 wr_addr_i,
    input  logic [31:0]                wr_data_i,
    input  logic                       clr_i,
    output logic [KEY_WORDS*32-1:0]    key_o,
    output logic [BLOCK_WORDS*32-1:0]  block_o
);

    logic [31:0] mem_q [TOTAL_WORDS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TOTAL_WORDS; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < TOTAL_WORDS; i++) mem_q[i] <= '0;
        end else if (wr_en_i) begin
            for (int i = 0; i < TOTAL_WORDS; i++) begin
                if (wr_addr_i == 6'(i)) mem_q[i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        key_o   = '0;
        block_o = '0;
        for (int i = 0; i < KEY_WORDS; i++) begin
            key_o[(KEY_WORDS-1-i)*32 +: 32] = mem_q[KEY_BASE+i];
        end
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            block_o[(BLOCK_WORDS-1-i)*32 +: 32] = mem_q[BLOCK_BASE+i];
        end
    end

endmodule

// File: rtl/hmac_cmd_sequencer.sv
// Front-end for the HMAC-384 core: word writes, init/next command issue, tag capture.
// HMAC_SEQ_ZEROIZE_EN: clear key/block on capture and let address 63 wipe the tag.
module hmac_cmd_sequencer
    import hmac_seq_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en_i,
    input  logic [5:0]                 wr_addr_i,
    input  logic [31:0]                wr_data_i,
    input  logic                       cmd_valid_i,
    input  logic                       cmd_init_i,
    input  logic                       cmd_next_i,
    output logic                       cmd_ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    input  logic [3:0]                 rd_addr_i,
    output logic [31:0]                rd_data_o,
    output logic                       core_init_o,
    output logic                       core_next_o,
    input  logic                       core_ready_i,
    input  logic                       core_tag_valid_i,
    output logic [KEY_WORDS*32-1:0]    core_key_o,
    output logic [BLOCK_WORDS*32-1:0]  core_block_o,
    input  logic [TAG_WORDS*32-1:0]    core_tag_i
);

    seq_state_e                 state_q, state_d;
    logic                       is_init_q, is_init_d;
    logic                       err_q, err_d;
    logic [TAG_WORDS*32-1:0]    tag_q, tag_d;

    logic idle;
    logic addr_in_range;
    logic zeroize_hit;
    logic clr_regs;
    logic wr_accept;
    logic cmd_bad;
    logic cmd_accept;

    assign idle          = (state_q == IDLE);
    assign addr_in_range = (wr_addr_i <= 6'(LAST_ADDR));

`ifdef HMAC_SEQ_ZEROIZE_EN
    assign zeroize_hit = wr_en_i && idle && (wr_addr_i == 6'(ZEROIZE_ADDR));
    assign clr_regs    = (state_q == CAPTURE);
`else
    assign zeroize_hit = 1'b0;
    assign clr_regs    = 1'b0;
`endif

    // Writes land only while idle so key/block stay frozen for the core.
    assign wr_accept   = wr_en_i && idle && addr_in_range;
    assign cmd_ready_o = idle && core_ready_i;
    assign cmd_bad     = cmd_valid_i && cmd_ready_o && (cmd_init_i == cmd_next_i);
    assign cmd_accept  = cmd_valid_i && cmd_ready_o && (cmd_init_i != cmd_next_i);
    assign busy_o      = !idle;
    assign err_o       = err_q;
    assign rd_data_o   = tag_word(tag_q, rd_addr_i);

    hmac_seq_wordreg u_wordreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .clr_i     (clr_regs),
        .key_o     (core_key_o),
        .block_o   (core_block_o)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            is_init_q <= 1'b0;
            err_q     <= 1'b0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_init_q <= is_init_d;
            err_q     <= err_d;
            tag_q     <= tag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_init_d   = is_init_q;
        tag_d       = tag_q;
        err_d       = cmd_bad || (wr_en_i && !wr_accept && !zeroize_hit);
        core_init_o = 1'b0;
        core_next_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d   = ISSUE;
                    is_init_d = cmd_init_i;
                end
                if (zeroize_hit) tag_d = '0;
            end
            ISSUE: begin
                core_init_o = is_init_q;
                core_next_o = !is_init_q;
                state_d     = WAIT_START;
            end
            // One dead cycle so a stale tag_valid from the previous run is not taken.
            WAIT_START: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (core_tag_valid_i) state_d = CAPTURE;
            end
            CAPTURE: begin
                tag_d   = core_tag_i;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
